io_bus_bridge: RTL

Memory-side bus bridge sitting directly downstream of the CPU core's byte-wide memory bus. Each cycle it decodes the CPU address and routes the access to the 128 KB synchronous RAM or to the I/O space at `0x30000`. The I/O space holds a UART RX FIFO, a UART TX FIFO, a free-running cycle counter and the program-stop latch. It returns read data with the fixed one-cycle read latency the core expects and throttles the core through `cpu_rdy` when TX buffering runs low.

---
 rtl/io_bus_bridge_if.sv | 34 +++
 rtl/io_bus_bridge.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/io_bus_bridge_if.sv
// Signal bundle between the CPU core, RAM, UART and io_bus_bridge.
// slave is the bridge's view; master is the surrounding system's view.
interface io_bus_bridge_if #(
    parameter int RAM_AW = 17
);
    logic [31:0]       cpu_a;
    logic [7:0]        cpu_dout;
    logic              cpu_wr;
    logic [7:0]        cpu_din;
    logic              cpu_rdy;
    logic [RAM_AW-1:0] ram_a;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              program_stop;

    modport slave (
        input  cpu_a, cpu_dout, cpu_wr, ram_rdata, rx_valid, rx_data, tx_ready,
        output cpu_din, cpu_rdy, ram_a, ram_we, ram_wdata, rx_ready, tx_valid,
               tx_data, program_stop
    );

    modport master (
        output cpu_a, cpu_dout, cpu_wr, ram_rdata, rx_valid, rx_data, tx_ready,
        input  cpu_din, cpu_rdy, ram_a, ram_we, ram_wdata, rx_ready, tx_valid,
               tx_data, program_stop
    );
endinterface

// File: rtl/io_bus_bridge.sv
// CPU memory-bus bridge: routes byte accesses to RAM or to the I/O page at 0x30000
// (UART RX/TX FIFOs, cycle counter, stop latch) with a fixed one-cycle read latency.
module io_bus_bridge #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8,
    parameter int RAM_AW   = 17
) (
    input  logic           clk_in,
    input  logic           rst_in,
    io_bus_bridge_if.slave bus
);
    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam logic [TXW:0] TX_FULL    = (TXW+1)'(TX_DEPTH);
    localparam logic [TXW:0] TX_RDY_MAX = (TXW+1)'(TX_DEPTH - 2);
    localparam logic [RXW:0] RX_FULL    = (RXW+1)'(RX_DEPTH);

    typedef enum logic [1:0] {SEL_RAM, SEL_RX, SEL_CNT} rd_sel_e;

    logic        io;
    logic [15:0] off;
    logic        rd_rx, rd_snap, rd_cnt_hi, wr_tx, wr_stop;
    logic        stop_req;
    logic        unused_addr_hi;

    assign io        = (bus.cpu_a[17:16] == 2'b11);
    assign off       = bus.cpu_a[15:0];
    assign rd_rx     = io & ~bus.cpu_wr & (off == 16'h0000);
    assign rd_snap   = io & ~bus.cpu_wr & (off == 16'h0004);
    assign rd_cnt_hi = io & ~bus.cpu_wr & ((off == 16'h0005) | (off == 16'h0006) | (off == 16'h0007));
    assign wr_stop   = io & bus.cpu_wr & (off == 16'h0004);
    // The terminator written by wr_stop skips this zero filter; user bytes may not be 0x00.
    assign wr_tx     = io & bus.cpu_wr & (off == 16'h0000) & (bus.cpu_dout != 8'h00) & ~stop_req;
    assign unused_addr_hi = ^bus.cpu_a[31:18];

    assign bus.ram_a     = bus.cpu_a[RAM_AW-1:0];
    assign bus.ram_wdata = bus.cpu_dout;
    assign bus.ram_we    = bus.cpu_wr & ~io;

    // ---------------- TX FIFO ----------------
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TXW-1:0] tx_rd_ptr, tx_wr_ptr;
    logic [TXW:0]   tx_count;
    logic           tx_push, tx_pop;
    logic [7:0]     tx_wdata;

    assign tx_wdata = wr_stop ? 8'h00 : bus.cpu_dout;
    assign tx_push  = (wr_tx | wr_stop) & (tx_count != TX_FULL);
    assign tx_pop   = bus.tx_valid & bus.tx_ready;

    // NOTE: storage arrays carry no reset; the reset pointers and counts define what is valid.
    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= tx_wdata;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    assign bus.tx_valid = (tx_count != '0);
    assign bus.tx_data  = bus.tx_valid ? tx_mem[tx_rd_ptr] : 8'h00;
    assign bus.cpu_rdy  = (tx_count <= TX_RDY_MAX) & ~stop_req;

    // ---------------- RX FIFO ----------------
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RXW-1:0] rx_rd_ptr, rx_wr_ptr;
    logic [RXW:0]   rx_count;
    logic           rx_push, rx_pop;

    assign bus.rx_ready = (rx_count != RX_FULL);
    assign rx_push      = bus.rx_valid & bus.rx_ready;
    assign rx_pop       = rd_rx & (rx_count != '0);

    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= bus.rx_data;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // ---------------- read path, counter, stop ----------------
    logic [31:0] cnt, cnt_snap;
    rd_sel_e     sel_q;
    logic        rd_vld_q;
    logic [7:0]  rx_byte_q;
    logic [1:0]  cnt_byte_q;
    logic        program_stop_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt            <= '0;
            cnt_snap       <= '0;
            sel_q          <= SEL_RAM;
            rd_vld_q       <= 1'b0;
            rx_byte_q      <= 8'h00;
            cnt_byte_q     <= 2'b00;
            stop_req       <= 1'b0;
            program_stop_q <= 1'b0;
        end else begin
            cnt        <= cnt + 32'd1;
            rd_vld_q   <= ~bus.cpu_wr;
            cnt_byte_q <= off[1:0];
            rx_byte_q  <= rx_pop ? rx_mem[rx_rd_ptr] : 8'h00;
            if (rd_snap) cnt_snap <= cnt;
            if (!io)                       sel_q <= SEL_RAM;
            else if (rd_snap || rd_cnt_hi) sel_q <= SEL_CNT;
            else                           sel_q <= SEL_RX;
            if (wr_stop) stop_req <= 1'b1;
            if (stop_req && (tx_count == '0)) program_stop_q <= 1'b1;
        end
    end

    assign bus.program_stop = program_stop_q;

    // NOTE: default first so every path assigns cpu_din and no latch is inferred.
    always_comb begin
        bus.cpu_din = 8'h00;
        if (rd_vld_q) begin
            case (sel_q)
                SEL_RAM: bus.cpu_din = bus.ram_rdata;
                SEL_RX:  bus.cpu_din = rx_byte_q;
                SEL_CNT: bus.cpu_din = cnt_snap[{cnt_byte_q, 3'b000} +: 8];
                default: bus.cpu_din = 8'h00;
            endcase
        end
    end
endmodule
